vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL take these parameters, one per line as name, default, meaning:
  - H_TOTAL, 800, pixels per line.
  - H_SYNC, 96, hs low width in pixels.
  - H_BP, 48, back porch in pixels.
  - H_ACTIVE, 640, visible pixels per line.
  - V_TOTAL, 525, lines per frame.
  - V_SYNC, 2, vs low width in lines.
  - V_BP, 33, back porch in lines.
  - V_ACTIVE, 480, visible lines per frame.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  - CLK  in  1  system clock.
  - RESET  in  1  synchronous, active-high reset.
  - PIX_EN  in  1  one-CLK pixel strobe, CLK/4.
  - hs  in  1  horizontal sync, active low.
  - vs  in  1  vertical sync, active low.
  - r  in  4  red pixel value.
  - g  in  4  green pixel value.
  - b  in  4  blue pixel value.
  - locked  out  1  timing verified.
  - de  out  1  active-region pixel.
  - row_addr  out  9  active row.
  - col_addr  out  10  active column.
  - frame_done  out  1  one-CLK pulse at end of frame.
  - px_count  out  19  non-black active pixels, last complete frame.
  - err_cnt  out  8  saturating timing-error count.

Function
REQ-003 All state SHALL update only on CLK edges with PIX_EN=1, except frame_done, which SHALL be high for exactly one CLK.
REQ-004 hs, vs, r, g, b SHALL be registered into stage S1 on PIX_EN; all decoding SHALL use S1 values; registered outputs SHALL lag their input pixel by exactly 2 PIX_EN strobes.
REQ-005 An hs edge SHALL be an S1 hs transition from 1 to 0; a vs edge SHALL be an S1 vs transition from 1 to 0.
REQ-006 The 10-bit hcnt SHALL be set to 0 on an hs edge and otherwise increment, saturating at 1023.
REQ-007 The 10-bit vcnt SHALL be set to 0 on a vs edge, increment on each hs edge that is not a vs edge, and saturate at 1023.
REQ-008 When vs and hs edges occur in the same strobe, both counters SHALL be cleared.
REQ-009 A line error SHALL be raised on an hs edge when the prior hcnt is not H_TOTAL-1; ignore the first hs edge after leaving HUNT.
REQ-010 A frame error SHALL be raised on a vs edge when the prior vcnt is not V_TOTAL-1.
REQ-011 The FSM SHALL have states HUNT, CHECK and LOCK:
  - HUNT goes to CHECK on a vs edge.
  - CHECK goes to LOCK on the second consecutive error-free vs edge.
  - Any error in CHECK or LOCK goes to HUNT.
  - locked SHALL be 1 only in LOCK.
REQ-012 Each line or frame error SHALL increment err_cnt, saturating at 255; simultaneous line and frame errors SHALL count 1.
REQ-013 de SHALL be 1 only when all of these hold:
  - locked=1;
  - H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE;
  - V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE.
REQ-014 When de=1, col_addr SHALL equal hcnt-(H_SYNC+H_BP) and row_addr SHALL equal vcnt-(V_SYNC+V_BP); when de=0 both SHALL hold 0.
REQ-015 An internal accumulator SHALL count pixels with de=1 and {r,g,b} not 0; it never exceeds 307200.
REQ-016 On each vs edge while locked, px_count SHALL load the accumulator, the accumulator SHALL clear, and frame_done SHALL pulse.
REQ-017 On a vs edge while not locked, the accumulator SHALL clear without a px_count load or frame_done pulse.
REQ-018 Loss of lock SHALL clear the accumulator.
REQ-019 Loss of lock SHALL NOT clear px_count, err_cnt, hcnt or vcnt.
REQ-020 When a PIX_EN strobe both loads px_count and sees a de pixel, that pixel SHALL count toward the next frame.

Reset
REQ-021 RESET=1 at any CLK edge SHALL, regardless of PIX_EN:
  - force state HUNT and locked=0;
  - clear de, row_addr, col_addr, frame_done, px_count, err_cnt, hcnt, vcnt, the accumulator and S1;
  - set S1 hs/vs to 1.
REQ-022 RESET asserted mid-frame SHALL discard the partial frame; no frame_done pulse SHALL follow it.

Verification
REQ-023 The bench SHALL cover each of these directed scenarios:
  - Nominal timing, all-black frames: locked rises at the third vs edge; px_count=0; err_cnt=0.
  - Locked frame with r=4'hF only at active pixel (col 10, row 20): de=1 and row_addr=20, col_addr=10 exactly 2 strobes after the pixel; next frame_done gives px_count=1.
  - All-white frame: px_count=307200.
  - While locked, one line of 799 pixels: locked falls at that hs edge; err_cnt increments by 1; relock after 2 clean frames.
  - Frame of 524 lines while locked: frame error, err_cnt+1, no frame_done, accumulator cleared.
  - RESET mid-frame while locked: all outputs 0 the next CLK; px_count=0; next lock only after the third vs edge.
  - 300 consecutive bad lines: err_cnt stops at 255.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA timing decoder: sync lock, active-area addressing, non-black pixel count
// Inputs are sampled into S1 on each pixel strobe; decode and outputs follow one strobe later.
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIX_EN,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        locked,
  output logic        de,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        frame_done,
  output logic [18:0] px_count,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DE_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_DE_HI = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_DE_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_DE_HI = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

  state_t      state;
  logic        good_vs;
  logic        line_chk_en;
  logic        s1_hs, s1_vs, hs_d, vs_d;
  logic [11:0] s1_rgb;
  logic [9:0]  hcnt, vcnt;
  logic [18:0] acc;

  logic        hs_edge, vs_edge;
  logic        line_err, frame_err, err;
  logic [9:0]  hcnt_nx, vcnt_nx;
  logic        de_nx, pix_hit;
  logic [9:0]  col_nx;
  logic [8:0]  row_nx;

  always_comb begin
    hs_edge   = hs_d & ~s1_hs;
    vs_edge   = vs_d & ~s1_vs;

    hcnt_nx = hcnt;
    if (hs_edge)
      hcnt_nx = 10'd0;
    else if (hcnt != 10'h3FF)
      hcnt_nx = hcnt + 10'd1;

    vcnt_nx = vcnt;
    if (vs_edge)
      vcnt_nx = 10'd0;
    else if (hs_edge && vcnt != 10'h3FF)
      vcnt_nx = vcnt + 10'd1;

    // Line length is only meaningful once a full line has been seen since reset/HUNT exit.
    line_err  = hs_edge && line_chk_en && (hcnt != H_LAST);
    frame_err = vs_edge && (state != HUNT) && (vcnt != V_LAST);
    err       = line_err | frame_err;

    // State only changes where hcnt_nx or vcnt_nx is 0, so the current state gates de correctly.
    de_nx   = (state == LOCK) &&
              (hcnt_nx >= H_DE_LO) && (hcnt_nx < H_DE_HI) &&
              (vcnt_nx >= V_DE_LO) && (vcnt_nx < V_DE_HI);
    pix_hit = de_nx && (s1_rgb != 12'd0);
    col_nx  = de_nx ? (hcnt_nx - H_DE_LO) : 10'd0;
    row_nx  = de_nx ? 9'(vcnt_nx - V_DE_LO) : 9'd0;
  end

  always_ff @(posedge CLK) begin
    frame_done <= 1'b0;
    if (RESET) begin
      state       <= HUNT;
      locked      <= 1'b0;
      good_vs     <= 1'b0;
      line_chk_en <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      s1_rgb      <= 12'd0;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      acc         <= 19'd0;
      de          <= 1'b0;
      row_addr    <= 9'd0;
      col_addr    <= 10'd0;
      px_count    <= 19'd0;
      err_cnt     <= 8'd0;
    end else if (PIX_EN) begin
      s1_hs    <= hs;
      s1_vs    <= vs;
      s1_rgb   <= {r, g, b};
      hs_d     <= s1_hs;
      vs_d     <= s1_vs;
      hcnt     <= hcnt_nx;
      vcnt     <= vcnt_nx;
      de       <= de_nx;
      row_addr <= row_nx;
      col_addr <= col_nx;

      if (err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      if (state == HUNT && vs_edge)
        line_chk_en <= 1'b0;
      else if (hs_edge)
        line_chk_en <= 1'b1;

      // A pixel seen on the vs strobe belongs to the frame that starts there.
      if (vs_edge)
        acc <= {18'd0, pix_hit};
      else if (pix_hit)
        acc <= acc + 19'd1;

      case (state)
        HUNT: begin
          if (vs_edge) begin
            state   <= CHECK;
            good_vs <= 1'b0;
          end
        end
        CHECK: begin
          if (err) begin
            state <= HUNT;
          end else if (vs_edge) begin
            if (good_vs) begin
              state  <= LOCK;
              locked <= 1'b1;
            end else begin
              good_vs <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (err) begin
            state  <= HUNT;
            locked <= 1'b0;
            acc    <= 19'd0;
          end else if (vs_edge) begin
            px_count   <= acc;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a reduced 16x26 raster
module tb_vga_sync_decoder;

  localparam int HT = 16, HS = 2, HB = 2, HA = 11;
  localparam int VT = 26, VS = 2, VB = 2, VA = 21;

  logic        CLK = 1'b0;
  logic        RESET, PIX_EN, hs, vs;
  logic [3:0]  r, g, b;
  logic        locked, de, frame_done;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [18:0] px_count;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b), .locked(locked), .de(de), .row_addr(row_addr),
    .col_addr(col_addr), .frame_done(frame_done), .px_count(px_count),
    .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (frame_done === 1'b1) fd_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_px(input logic h, input logic v, input logic [11:0] c);
    hs = h;
    vs = v;
    {r, g, b} = c;
    PIX_EN = 1'b1;
    @(posedge CLK); #1;
    PIX_EN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // mode 0: black, 1: white everywhere, 2: single red pixel at col 10 row 20
  task automatic send_line(input int npix, input logic v, input int l, input int mode);
    logic [11:0] c;
    for (int x = 0; x < npix; x++) begin
      c = 12'd0;
      if (mode == 1) c = 12'hFFF;
      if (mode == 2 && x == HS + HB + 10 && l == VS + VB + 20) c = 12'hF00;
      send_px((x < HS) ? 1'b0 : 1'b1, v, c);
      if (mode == 2) begin
        if (l == VS + VB + 20 && x == HS + HB + 11) begin
          check("px_de", de, 1);
          check("px_row", row_addr, 20);
          check("px_col", col_addr, 10);
        end
        if (l == VS + VB && x == HS + HB + 1) begin
          check("first_de", de, 1);
          check("first_row", row_addr, 0);
          check("first_col", col_addr, 0);
        end
        if (l == VS + VB + 20 && x == 1) begin
          check("blank_de", de, 0);
          check("blank_col", col_addr, 0);
          check("blank_row", row_addr, 0);
        end
      end
    end
  endtask

  task automatic send_frame(input int nlines, input int short_line, input int mode);
    for (int l = 0; l < nlines; l++)
      send_line((l == short_line) ? HT - 1 : HT, (l < VS) ? 1'b0 : 1'b1, l, mode);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_de"}, de, 0);
    check({tag, "_row"}, row_addr, 0);
    check({tag, "_col"}, col_addr, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_px"}, px_count, 0);
    check({tag, "_err"}, err_cnt, 0);
  endtask

  initial begin
    RESET = 1'b1; PIX_EN = 1'b0; hs = 1'b1; vs = 1'b1; r = 4'd0; g = 4'd0; b = 4'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    RESET = 1'b0;

    // nominal black frames: lock on the third vs edge
    send_frame(VT, -1, 0);
    check("lock_a", locked, 0);
    send_frame(VT, -1, 0);
    check("lock_b", locked, 0);
    send_frame(VT, -1, 0);
    check("lock_c", locked, 1);
    check("err_c", err_cnt, 0);
    check("fd_c", fd_count, 0);
    send_frame(VT, -1, 0);
    check("fd_d", fd_count, 1);
    check("px_d", px_count, 0);

    // single red pixel, then all-white frame
    send_frame(VT, -1, 2);
    send_frame(VT, -1, 0);
    check("px_single", px_count, 1);
    check("fd_f", fd_count, 3);
    send_frame(VT, -1, 1);
    send_frame(VT, -1, 0);
    check("px_white", px_count, HA * VA);
    check("fd_h", fd_count, 5);

    // short line while locked, relock after two clean frames
    send_frame(VT, 10, 0);
    check("short_locked", locked, 0);
    check("short_err", err_cnt, 1);
    check("short_fd", fd_count, 6);
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    check("relock_k", locked, 0);
    send_frame(VT, -1, 0);
    check("relock_l", locked, 1);
    check("relock_err", err_cnt, 1);
    check("relock_fd", fd_count, 6);

    // one-line-short frame while locked
    send_frame(VT, -1, 1);
    send_frame(VT - 1, -1, 1);
    check("short_frame_fd", fd_count, 8);
    check("short_frame_px", px_count, HA * VA);
    send_frame(VT, -1, 0);
    check("frame_err", err_cnt, 2);
    check("frame_err_locked", locked, 0);
    check("frame_err_fd", fd_count, 8);
    check("frame_err_px", px_count, HA * VA);
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    check("relock_r", locked, 1);

    // reset mid-frame while locked
    for (int l = 0; l < 10; l++) send_line(HT, (l < VS) ? 1'b0 : 1'b1, l, 1);
    for (int x = 0; x < 5; x++) send_px((x < HS) ? 1'b0 : 1'b1, 1'b1, 12'hFFF);
    check("pre_reset_fd", fd_count, 9);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check_zero("midreset");
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    check("rst_lock_u", locked, 0);
    send_frame(VT, -1, 0);
    check("rst_lock_v", locked, 1);
    check("rst_fd", fd_count, 9);
    check("rst_px", px_count, 0);

    // 300 consecutive 6-pixel lines: err_cnt saturates
    for (int n = 0; n < 300; n++) begin
      send_line(6, 1'b1, VS + VB + 1, 0);
      if (n == 99) check("bad_100", err_cnt, 99);
    end
    send_px(1'b0, 1'b1, 12'd0);
    send_px(1'b0, 1'b1, 12'd0);
    check("err_sat", err_cnt, 255);
    check("bad_locked", locked, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
